// File: rtl/gppcu_cmd_queue.sv
// gppcu_cmd_queue -- single-clock host command front-end for the GPPCU core.
//
// Purpose:
//   Synchronises the toggled host strobe iCMD[31], turns its rising edge into
//   a one-cycle command strobe and decodes wparam into one of these actions:
//   a push into a DEPTH-deep show-ahead instruction FIFO, a local-memory
//   read/write, a global-memory write, or a FIFO flush.
//
// Optional feature (macro GPPCU_CMDQ_STATUS_EN):
//   When defined, wparam 5 (STATUS) loads oDATA with
//   {ovf, full, empty, zero pad, level}. When undefined, wparam 5 is ignored.
//
// Ports:
//   iACLK / inRST          clock, asynchronous active-low reset
//   iCMD, iDATA            host command word ([31] strobe, [30:24] wparam,
//                          [23:16] lparam, [15:0] command) and host data
//   oDATA                  host read-back register
//   oINSTR, oINSTR_VALID,
//   iINSTR_READY           FIFO head towards the core (valid/ready)
//   oLMEM_*, iLMEM_RDATA   registered local-memory access strobes/addr/data
//   oGMEM_*                registered global-memory write strobe/addr/data
//   oFULL, oEMPTY,
//   oLEVEL, oOVF           FIFO status; oOVF is sticky until FLUSH
module gppcu_cmd_queue #(
  parameter int DBW         = 32,
  parameter int DEPTH       = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     iACLK,
  input  logic                     inRST,
  input  logic [31:0]              iCMD,
  input  logic [DBW-1:0]           iDATA,
  output logic [DBW-1:0]           oDATA,
  output logic [DBW-1:0]           oINSTR,
  output logic                     oINSTR_VALID,
  input  logic                     iINSTR_READY,
  output logic [7:0]               oLMEM_THREAD_SEL,
  output logic [15:0]              oLMEM_ADDR,
  output logic [DBW-1:0]           oLMEM_WDATA,
  input  logic [DBW-1:0]           iLMEM_RDATA,
  output logic                     oLMEM_RD,
  output logic                     oLMEM_WR,
  output logic [15:0]              oGMEM_ADDR,
  output logic [DBW-1:0]           oGMEM_WDATA,
  output logic                     oGMEM_WR,
  output logic                     oFULL,
  output logic                     oEMPTY,
  output logic [$clog2(DEPTH):0]   oLEVEL,
  output logic                     oOVF
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  // Strobe synchroniser plus edge register
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   edge_reg;
  logic                   cmd_stb;

  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      sync_reg <= '0;
      edge_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], iCMD[31]};
      edge_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  // Rising edge only; the falling edge of the toggled strobe is ignored.
  assign cmd_stb = sync_reg[SYNC_STAGES-1] & ~edge_reg;

  // Command decode
  logic [6:0]  wparam;
  logic [7:0]  lparam;
  logic [15:0] command;
  logic        do_push, do_rdl, do_wrl, do_wrg, do_flush;

  assign wparam   = iCMD[30:24];
  assign lparam   = iCMD[23:16];
  assign command  = iCMD[15:0];
  assign do_push  = cmd_stb && (wparam == 7'd0);
  assign do_rdl   = cmd_stb && (wparam == 7'd1);
  assign do_wrl   = cmd_stb && (wparam == 7'd2);
  assign do_wrg   = cmd_stb && (wparam == 7'd3);
  assign do_flush = cmd_stb && (wparam == 7'd4);

  // Instruction FIFO: pointers carry one extra wrap bit so that
  // wr - rd directly gives the level 0..DEPTH.
  logic [DBW-1:0] mem [DEPTH];
  logic [AW:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]    level;
  logic           full, empty, push_ok, pop;
  logic           ovf_reg;

  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign full    = (level == DEPTH_W);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign push_ok = do_push && !full;
  assign pop     = !empty && iINSTR_READY;

  always_ff @(posedge iACLK) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= iDATA;
    end
  end

  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      ovf_reg    <= 1'b0;
    end else if (do_flush) begin
      // Flush overrides any pop in the same cycle; no push can coincide.
      rd_ptr_reg <= wr_ptr_reg;
      ovf_reg    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      // Level is sampled before any same-cycle pop, so a full push drops.
      if (do_push && full) ovf_reg <= 1'b1;
    end
  end

  assign oINSTR       = mem[rd_ptr_reg[AW-1:0]];
  assign oINSTR_VALID = !empty;
  assign oFULL        = full;
  assign oEMPTY       = empty;
  assign oLEVEL       = level;
  assign oOVF         = ovf_reg;

  // Memory access strobes and address/data registers
  logic rd_pend_reg;

  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      oLMEM_RD         <= 1'b0;
      oLMEM_WR         <= 1'b0;
      oGMEM_WR         <= 1'b0;
      rd_pend_reg      <= 1'b0;
      oLMEM_THREAD_SEL <= '0;
      oLMEM_ADDR       <= '0;
      oLMEM_WDATA      <= '0;
      oGMEM_ADDR       <= '0;
      oGMEM_WDATA      <= '0;
    end else begin
      oLMEM_RD    <= do_rdl;
      oLMEM_WR    <= do_wrl;
      oGMEM_WR    <= do_wrg;
      // Read data arrives the cycle after the read pulse.
      rd_pend_reg <= oLMEM_RD;
      if (do_rdl || do_wrl || do_wrg) begin
        oLMEM_THREAD_SEL <= lparam;
        oLMEM_ADDR       <= command;
        oLMEM_WDATA      <= iDATA;
        oGMEM_ADDR       <= command;
        oGMEM_WDATA      <= iDATA;
      end
    end
  end

  // Host read-back register
`ifdef GPPCU_CMDQ_STATUS_EN
  logic           status_pend_reg;
  logic [DBW-1:0] status_word;

  always_comb begin
    status_word        = '0;
    status_word[AW:0]  = level;
    status_word[DBW-1] = ovf_reg;
    status_word[DBW-2] = full;
    status_word[DBW-3] = empty;
  end

  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      status_pend_reg <= 1'b0;
      oDATA           <= '0;
    end else begin
      status_pend_reg <= cmd_stb && (wparam == 7'd5);
      if (rd_pend_reg) begin
        oDATA <= iLMEM_RDATA;
      end else if (status_pend_reg) begin
        oDATA <= status_word;
      end
    end
  end
`else
  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      oDATA <= '0;
    end else if (rd_pend_reg) begin
      oDATA <= iLMEM_RDATA;
    end
  end
`endif

endmodule

// File: tb/tb_gppcu_cmd_queue.sv
// Testbench for gppcu_cmd_queue (DEPTH = 4, SYNC_STAGES = 2).
// Pushed words go into a scoreboard queue when the command is issued; a
// monitor pops and compares them whenever the core-side handshake fires.
module tb_gppcu_cmd_queue;

  localparam int DBW   = 32;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      cmd;
  logic [DBW-1:0]   data;
  logic [DBW-1:0]   rdata;
  logic             ready;
  logic [DBW-1:0]   o_data, o_instr, o_lwdata, o_gwdata;
  logic             o_valid, o_lrd, o_lwr, o_gwr, o_full, o_empty, o_ovf;
  logic [7:0]       o_sel;
  logic [15:0]      o_laddr, o_gaddr;
  logic [2:0]       o_level;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  gppcu_cmd_queue #(.DBW(DBW), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .iACLK(clk), .inRST(rst_n), .iCMD(cmd), .iDATA(data),
    .oDATA(o_data), .oINSTR(o_instr), .oINSTR_VALID(o_valid),
    .iINSTR_READY(ready), .oLMEM_THREAD_SEL(o_sel), .oLMEM_ADDR(o_laddr),
    .oLMEM_WDATA(o_lwdata), .iLMEM_RDATA(rdata), .oLMEM_RD(o_lrd),
    .oLMEM_WR(o_lwr), .oGMEM_ADDR(o_gaddr), .oGMEM_WDATA(o_gwdata),
    .oGMEM_WR(o_gwr), .oFULL(o_full), .oEMPTY(o_empty), .oLEVEL(o_level),
    .oOVF(o_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one host command; returns #1 after the edge ending cycle N (so in N+1).
  task automatic issue(input logic [6:0] wp, input logic [7:0] lp,
                       input logic [15:0] cm, input logic [31:0] d);
    @(negedge clk);
    cmd[30:0] = {wp, lp, cm};
    data      = d;
    repeat (SYNC + 1) @(negedge clk);
    cmd[31] = 1'b1;
    if (wp == 7'd0 && sb.size() < DEPTH) sb.push_back(d);
    if (wp == 7'd4) sb.delete();
    $display("cmd wparam=%0d lparam=%h command=%h data=%h", wp, lp, cm, d);
    repeat (SYNC + 1) @(posedge clk);
    #1;
  endtask

  task automatic release_stb();
    repeat (2) @(negedge clk);
    cmd[31] = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
  endtask

  // Scoreboard monitor: samples the handshake just after the falling edge.
  always @(negedge clk) begin
    #1;
    if (rst_n && o_valid && ready) begin
      if (sb.size() == 0) begin
        chk("pop_unexpected", o_instr, 32'hxxxx_xxxx);
      end else begin
        $display("pop data=%h", o_instr);
        chk("pop_data", o_instr, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [6:0]  wp;
    logic [7:0]  lp;
    logic [15:0] cm;
    logic [31:0] d;
    logic [2:0]  pulses;   // {lmem_wr, gmem_wr, lmem_rd} in N+1
    logic [7:0]  sel;
    logic [15:0] addr;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{7'd2, 8'h05, 16'h0100, 32'h0000_CAFE, 3'b100, 8'h05, 16'h0100, 32'h0000_CAFE};
    vecs[1] = '{7'd3, 8'h12, 16'h2000, 32'h1234_5678, 3'b010, 8'h12, 16'h2000, 32'h1234_5678};
    vecs[2] = '{7'd7, 8'h7F, 16'hFFFF, 32'hFFFF_FFFF, 3'b000, 8'h12, 16'h2000, 32'h1234_5678};
    vecs[3] = '{7'd2, 8'hA5, 16'h00FF, 32'h0000_0000, 3'b100, 8'hA5, 16'h00FF, 32'h0000_0000};
    vecs[4] = '{7'd6, 8'h01, 16'h1111, 32'h2222_2222, 3'b000, 8'hA5, 16'h00FF, 32'h0000_0000};

    rst_n = 1'b0; cmd = '0; data = '0; rdata = '0; ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_full",  32'(o_full),  32'd0);
    chk("rst_ovf",   32'(o_ovf),   32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_level", 32'(o_level), 32'd0);
    chk("rst_data",  o_data,       32'd0);
    chk("rst_pulses", 32'({o_lwr, o_gwr, o_lrd}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three pushes, then drain on consecutive cycles
    issue(7'd0, 8'h00, 16'h0000, 32'h11); release_stb();
    issue(7'd0, 8'h00, 16'h0000, 32'h22); release_stb();
    issue(7'd0, 8'h00, 16'h0000, 32'h33); release_stb();
    chk("p3_level", 32'(o_level), 32'd3);
    chk("p3_empty", 32'(o_empty), 32'd0);
    chk("p3_head",  o_instr,      32'h11);
    @(negedge clk); ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("drain_level", 32'(o_level), 32'd1);
    @(posedge clk); #1;
    chk("drain_empty", 32'(o_empty), 32'd1);
    @(negedge clk); ready = 1'b0;

    // Overflow at DEPTH, drain, flush
    for (int i = 0; i < 5; i++) begin
      issue(7'd0, 8'h00, 16'h0000, 32'h100 + 32'(i));
      if (i == 3) begin
        chk("fill_full", 32'(o_full), 32'd1);
        chk("fill_ovf0", 32'(o_ovf),  32'd0);
      end
      if (i == 4) begin
        chk("ovf_set",   32'(o_ovf),   32'd1);
        chk("ovf_level", 32'(o_level), 32'd4);
      end
      release_stb();
    end
    @(negedge clk); ready = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk("ovf_drained", 32'(o_empty), 32'd1);
    chk("ovf_sticky",  32'(o_ovf),   32'd1);
    @(negedge clk); ready = 1'b0;
    issue(7'd4, 8'h00, 16'h0000, 32'h0);
    chk("flush_ovf",   32'(o_ovf),   32'd0);
    chk("flush_level", 32'(o_level), 32'd0);
    release_stb();
    issue(7'd0, 8'h00, 16'h0000, 32'h55); release_stb();
    issue(7'd0, 8'h00, 16'h0000, 32'h66); release_stb();
    chk("preflush_level", 32'(o_level), 32'd2);
    issue(7'd4, 8'h00, 16'h0000, 32'h0);
    chk("flush2_valid", 32'(o_valid), 32'd0);
    chk("flush2_level", 32'(o_level), 32'd0);
    release_stb();

    // Wrap-around with READY held high
    @(negedge clk); ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      issue(7'd0, 8'h00, 16'h0000, 32'hA0 + 32'(i));
      chk("wrap_level_le1", 32'(o_level <= 3'd1), 32'd1);
      release_stb();
    end
    chk("wrap_ovf",   32'(o_ovf),   32'd0);
    chk("wrap_empty", 32'(o_empty), 32'd1);
    @(negedge clk); ready = 1'b0;

    // Table-driven memory access commands
    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].wp, vecs[i].lp, vecs[i].cm, vecs[i].d);
      chk("tbl_pulses", 32'({o_lwr, o_gwr, o_lrd}), 32'(vecs[i].pulses));
      chk("tbl_sel",    32'(o_sel),   32'(vecs[i].sel));
      chk("tbl_laddr",  32'(o_laddr), 32'(vecs[i].addr));
      chk("tbl_lwdata", o_lwdata,     vecs[i].wdata);
      chk("tbl_gaddr",  32'(o_gaddr), 32'(vecs[i].addr));
      chk("tbl_gwdata", o_gwdata,     vecs[i].wdata);
      @(posedge clk); #1;
      chk("tbl_pulse_end", 32'({o_lwr, o_gwr, o_lrd}), 32'd0);
      release_stb();
    end
    chk("tbl_fifo_untouched", 32'(o_level), 32'd0);

    // Local read: capture in N+2, visible from N+3
    rdata = 32'hDEAD;
    issue(7'd1, 8'h03, 16'h0040, 32'h0);
    chk("rdl_pulse", 32'(o_lrd),   32'd1);
    chk("rdl_addr",  32'(o_laddr), 32'h0040);
    chk("rdl_n1",    o_data,       32'd0);
    @(posedge clk); #1;
    rdata = 32'hBEEF;
    chk("rdl_pulse_end", 32'(o_lrd), 32'd0);
    chk("rdl_n2",    o_data, 32'd0);
    @(posedge clk); #1;
    chk("rdl_n3",    o_data, 32'hBEEF);
    rdata = 32'h5555;
    @(posedge clk); #1;
    chk("rdl_hold",  o_data, 32'hBEEF);
    release_stb();

    // Strobe held high: one command; second rising edge: second command
    issue(7'd0, 8'h00, 16'h0000, 32'h77);
    repeat (20) @(negedge clk);
    chk("held_level", 32'(o_level), 32'd1);
    cmd[31] = 1'b0;
    repeat (6) @(negedge clk);
    chk("fall_level", 32'(o_level), 32'd1);
    issue(7'd0, 8'h00, 16'h0000, 32'h88);
    chk("edge2_level", 32'(o_level), 32'd2);
    release_stb();

    // Reset mid-operation with a read pending
    rdata = 32'h1234;
    issue(7'd1, 8'h09, 16'h0ABC, 32'hFEED);
    rst_n = 1'b0;
    cmd[31] = 1'b0;
    sb.delete();
    #1;
    chk("mrst_level", 32'(o_level), 32'd0);
    chk("mrst_empty", 32'(o_empty), 32'd1);
    chk("mrst_valid", 32'(o_valid), 32'd0);
    chk("mrst_data",  o_data,       32'd0);
    chk("mrst_rd",    32'(o_lrd),   32'd0);
    chk("mrst_addr",  32'(o_laddr), 32'd0);
    chk("mrst_gwdata", o_gwdata,    32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mrst_read_dropped", o_data, 32'd0);

    // STATUS after reset
    issue(7'd5, 8'h00, 16'h0000, 32'h0);
    @(posedge clk); #1;
`ifdef GPPCU_CMDQ_STATUS_EN
    chk("status_word", o_data, 32'h2000_0000);
`else
    chk("status_ignored", o_data, 32'h0);
`endif
    release_stb();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gppcu_cmd_queue.md
Name: gppcu_cmd_queue

Overview:
Parametrised single-clock host command front-end for the GPPCU core. It replaces the dual-clock test queue with a strobe-synchronised command decoder. It also has a DEPTH-deep instruction FIFO with valid/ready to the core, full/empty/level flags, sticky overflow, flush, and registered local/global memory access strobes. It sits between the host register interface (iCMD/iDATA) and GPPCU_CORE.

Parameters:
DBW, 32, instruction/data width
DEPTH, 128, FIFO capacity in words (power of 2, >= 4); AW = log2(DEPTH) derived internally
SYNC_STAGES, 2, synchroniser flops on the host strobe iCMD[31] (>= 2)

Ports:
iACLK  in  1  sole clock; all logic rising-edge
inRST  in  1  asynchronous, active-low reset
iCMD  in  32  [31] host strobe (toggled, asynchronous); [30:24] wparam; [23:16] lparam; [15:0] command
iDATA  in  DBW  host write data / instruction
oDATA  out  DBW  host read-back register
oINSTR  out  DBW  FIFO head word (show-ahead)
oINSTR_VALID  out  1  head valid
iINSTR_READY  in  1  core accepts head
oLMEM_THREAD_SEL  out  8  registered lparam
oLMEM_ADDR  out  16  registered command
oLMEM_WDATA  out  DBW  registered iDATA
iLMEM_RDATA  in  DBW  local-memory read data, valid the cycle after oLMEM_RD
oLMEM_RD  out  1  one-cycle read pulse
oLMEM_WR  out  1  one-cycle write pulse
oGMEM_ADDR  out  16  registered command
oGMEM_WDATA  out  DBW  registered iDATA
oGMEM_WR  out  1  one-cycle global write pulse
oFULL  out  1  level == DEPTH
oEMPTY  out  1  level == 0
oLEVEL  out  AW+1  words held
oOVF  out  1  sticky: push dropped while full

Behaviour:
- Reset (async assert, sync deassert by the iACLK domain): pointers = 0, level = 0, oEMPTY = 1, oFULL = 0, oOVF = 0, oINSTR_VALID = 0, oDATA = 0, all strobes = 0, address/data regs = 0, synchroniser = 0. Reset mid-operation discards FIFO contents and any pending read.
- Strobe: iCMD[31] passes through SYNC_STAGES flops plus an edge register. A rising edge yields a one-cycle cmd_stb (cycle N). iCMD[30:0] and iDATA are sampled in cycle N. The host holds them stable from at least SYNC_STAGES+1 cycles before the edge until 2 cycles after it. A falling edge does nothing.
- Decode on cmd_stb, by wparam:
  - 0 PUSH: write iDATA into the FIFO.
  - 1 RDL: oLMEM_RD = 1 in N+1; iLMEM_RDATA is captured in N+2; oDATA is updated and visible from N+3.
  - 2 WRL: oLMEM_WR = 1 in N+1.
  - 3 WRG: oGMEM_WR = 1 in N+1.
  - 4 FLUSH: see below.
  - Others: no effect.
- Address/data regs load at the end of N for wparam 1/2/3 and hold otherwise.
- FIFO: storage array with pointers AW+1 bits wide, wrap modulo DEPTH via the MSB.
  - oINSTR_VALID = !empty. oINSTR is the head word while valid.
  - Pop occurs when oINSTR_VALID && iINSTR_READY; the next word is presented the following cycle.
  - Push latency: push at N into an empty queue gives oINSTR_VALID = 1 in N+1.
  - Level/flags update the cycle after each push/pop. Simultaneous push and pop leaves the level unchanged.
- Full: a push with level == DEPTH at the start of the cycle is dropped and sets oOVF, even if a pop occurs in the same cycle. Queue contents are unchanged.
- Empty: iINSTR_READY while empty has no effect; the level never underflows.
- FLUSH: in N+1 pointers are equalised, level = 0, oINSTR_VALID = 0, oOVF = 0. A pop in cycle N is discarded by the flush (flush wins).
- oLEVEL counts 0..DEPTH inclusive.

Optional Feature:
GPPCU_CMDQ_STATUS_EN:
- Defined: wparam 5 STATUS loads oDATA at the end of N+1 with {oOVF, oFULL, oEMPTY, zero-pad, oLEVEL}, right-aligned level in bits [AW:0] and flags in DBW-1..DBW-3.
- Undefined: wparam 5 is ignored and oDATA is unchanged.

Test Plan:
- Reset, then 3 PUSH toggles with iDATA = 0x11, 0x22, 0x33 and iINSTR_READY = 0 -> oLEVEL = 3, oEMPTY = 0, oINSTR = 0x11. Raising READY then pops 0x11, 0x22, 0x33 on consecutive cycles, then oEMPTY = 1.
- DEPTH = 4: push 5 words -> oFULL = 1 after the 4th, the 5th is dropped, oOVF = 1, and the words popped are the first 4 in order. FLUSH -> oOVF = 0, oLEVEL = 0.
- Wrap-around: DEPTH = 4, interleave 10 pushes/pops with READY held high -> data order preserved, oLEVEL never > 1, no OVF.
- WRL lparam = 5, command = 0x0100, iDATA = 0xCAFE -> oLMEM_WR pulses 1 cycle with THREAD_SEL = 5, ADDR = 0x0100, WDATA = 0xCAFE. RDL with iLMEM_RDATA = 0xBEEF -> oDATA = 0xBEEF at N+3.
- Strobe held high 20 cycles -> exactly one command executed. Glitch-free toggles only on rising edges; two edges give two pushes.
- Assert inRST mid-burst with level 2 -> all outputs return to reset values immediately. With STATUS_EN, STATUS after reset -> oDATA shows EMPTY = 1, level 0.
